// File: rtl/alu_share_arbiter.sv
// Two-requester valid/ready front end for one shared external ALU: arbitrate, register operands, hold result.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 always win ties; otherwise ties alternate round-robin.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,

  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,

  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,

  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result,

  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     owner_q;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [DATA_WIDTH-1:0]    a_q;
  logic [DATA_WIDTH-1:0]    b_q;
  logic [DATA_WIDTH-1:0]    rsp_data_q;
  logic                     rsp0_valid_q;
  logic                     rsp1_valid_q;
  logic                     busy_q;

  logic grant;
  logic req_any;
  logic rsp_done;

  assign req_any = req0_valid | req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb grant = !req0_valid;
`else
  logic last_grant_q;

  // On a tie the requester not served last time wins.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = !req0_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_grant_q <= 1'b1;
    else if (rsp_done) last_grant_q <= owner_q;
  end
`endif

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;
  assign rsp_done   = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            owner_q <= grant;
            op_q    <= grant ? req1_op : req0_op;
            a_q     <= grant ? req1_a  : req0_a;
            b_q     <= grant ? req1_b  : req0_b;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q   <= alu_result;
          rsp0_valid_q <= !owner_q;
          rsp1_valid_q <=  owner_q;
          state_q      <= RESP;
        end
        RESP: begin
          // Only the owner's ready completes; the other channel's ready is ignored.
          if (rsp_done) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_data   = rsp_data_q;
  assign alu_srca   = a_q;
  assign alu_srcb   = b_q;
  assign alu_op     = op_q;
  assign busy       = busy_q;

endmodule
